// File: rtl/swipt_pkg.sv
// Shared types and defaults for the SWIPT ADC conditioning path.
package swipt_pkg;
   localparam int DEF_ADC_W      = 12;
   localparam int DEF_DECIM      = 100;
   localparam int DEF_LOG2_N     = 6;
   localparam int DEF_SETTLE_CYC = 1000;
   localparam logic [DEF_ADC_W-1:0] ADC_FS = 12'hFFF;

   typedef enum logic [1:0] {IDLE, SETTLE, ACCUM, DONE} state_t;
endpackage

// File: rtl/tick_gen.sv
// Decimation counter: tick marks the sample slot, wrap marks the last clock of a slot.
module tick_gen
   import swipt_pkg::*;
#(
   parameter int DECIM = DEF_DECIM
)(
   input  logic clk,
   input  logic nrst,
   input  logic clr,
   output logic tick,
   output logic wrap
);
   localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam logic [CW-1:0] LAST = CW'(DECIM - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)
         cnt <= '0;
      else if (clr || wrap)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   assign tick = (cnt == '0);
   assign wrap = (cnt == LAST);
endmodule

// File: rtl/adc_window_stats.sv
// Settle, then decimate the ADC stream over a 2^LOG2_N window and publish mean/peak/trough.
module adc_window_stats
   import swipt_pkg::*;
#(
   parameter int ADC_W      = DEF_ADC_W,
   parameter int DECIM      = DEF_DECIM,
   parameter int LOG2_N     = DEF_LOG2_N,
   parameter int SETTLE_CYC = DEF_SETTLE_CYC
)(
   input  logic             clk,
   input  logic             nrst,
   input  logic             swiptAlive,
   input  logic             start,
   input  logic             cont,
   input  logic [ADC_W-1:0] ADC,
   output logic             busy,
   output logic             valid,
   output logic [ADC_W-1:0] mean,
   output logic [ADC_W-1:0] peak,
   output logic [ADC_W-1:0] trough
);
   localparam int AW = ADC_W + LOG2_N;
   localparam int NW = LOG2_N + 1;
   localparam logic [NW-1:0] N_SAMP = NW'(1 << LOG2_N);
   localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [SW-1:0] SET_LAST = SW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

   function automatic logic [ADC_W-1:0] trunc_mean(input logic [AW-1:0] a);
      return a[AW-1:LOG2_N];
   endfunction

   state_t            state, state_nx;
   logic [ADC_W-1:0]  adc_p0;
   logic [AW-1:0]     acc, acc_nx;
   logic [ADC_W-1:0]  run_max, run_min, max_nx, min_nx;
   logic [NW-1:0]     samp_cnt, samp_nx;
   logic [SW-1:0]     set_cnt;
   logic              tick, wrap, win_last;

   tick_gen #(.DECIM(DECIM)) u_tick (
      .clk  (clk),
      .nrst (nrst),
      .clr  (state != ACCUM),
      .tick (tick),
      .wrap (wrap)
   );

   // p0: input register; every accumulated sample comes from here
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)
         adc_p0 <= '0;
      else
         adc_p0 <= ADC;
   end

   always_comb begin
      acc_nx   = acc + (tick ? AW'(adc_p0) : AW'(0));
      max_nx   = (tick && (adc_p0 > run_max)) ? adc_p0 : run_max;
      min_nx   = (tick && (adc_p0 < run_min)) ? adc_p0 : run_min;
      samp_nx  = samp_cnt + NW'(tick);
      win_last = wrap && (samp_nx == N_SAMP);
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start && swiptAlive) state_nx = (SETTLE_CYC == 0) ? ACCUM : SETTLE;
         SETTLE:  if (!swiptAlive) state_nx = IDLE;
                  else if (set_cnt == SET_LAST) state_nx = ACCUM;
         ACCUM:   if (!swiptAlive) state_nx = IDLE;
                  else if (win_last) state_nx = DONE;
         DONE:    state_nx = (cont && swiptAlive) ? ACCUM : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state    <= IDLE;
         set_cnt  <= '0;
         samp_cnt <= '0;
         acc      <= '0;
         run_max  <= '0;
         run_min  <= '1;
      end else begin
         state   <= state_nx;
         set_cnt <= (state == SETTLE) ? set_cnt + 1'b1 : '0;
         // Running stats are held cleared outside ACCUM so every window starts fresh
         if (state == ACCUM) begin
            samp_cnt <= samp_nx;
            acc      <= acc_nx;
            run_max  <= max_nx;
            run_min  <= min_nx;
         end else begin
            samp_cnt <= '0;
            acc      <= '0;
            run_max  <= '0;
            run_min  <= '1;
         end
      end
   end

   // p1: results latched on the edge into DONE, including the window's final sample
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         mean   <= '0;
         peak   <= '0;
         trough <= '0;
      end else if (state == ACCUM && state_nx == DONE) begin
         mean   <= trunc_mean(acc_nx);
         peak   <= max_nx;
         trough <= min_nx;
      end
   end

   assign busy  = (state != IDLE);
   assign valid = (state == DONE);
endmodule

// File: doc/adc_window_stats.md
Name: adc_window_stats

Overview:
Conditions the 12-bit ADC word from the analog network before the frequency-optimisation and mean-current stages consume it.
- On a start request, waits a settle interval after a SWIPT operating-point change.
- Then takes decimated samples over a fixed power-of-two window.
- Publishes the window's mean, maximum and minimum with a one-cycle valid strobe.
- Sits between the ADC bus and the Freq/GetMeanCurrent consumers, driven by the toplevel program sequencer.

Parameters:
ADC_W, 12, ADC sample width
DECIM, 100, clocks per sample (>=1); 100 gives 1 MS/s at the 100 MHz clk
LOG2_N, 6, log2 of samples per window (N = 64)
SETTLE_CYC, 1000, clocks discarded after start (0 allowed = no settle)

Ports:
clk  in  1  system clock, 100 MHz
nrst  in  1  asynchronous active-low reset
swiptAlive  in  1  heartbeat-qualified enable; low aborts any window
start  in  1  request a measurement; sampled only in IDLE
cont  in  1  continuous mode; when high at window end, the next window starts immediately with no settle
ADC  in  ADC_W  raw ADC word
busy  out  1  high from start acceptance until the valid cycle inclusive
valid  out  1  one-cycle strobe; mean/peak/trough are updated in this cycle
mean  out  ADC_W  floor(sum / N) of the last completed window
peak  out  ADC_W  maximum sample of the last completed window
trough  out  ADC_W  minimum sample of the last completed window

Behaviour:
- Reset (async, nrst low): state IDLE; busy, valid, mean, peak, trough = 0; all counters and accumulator = 0.
- ADC is registered once every clock. Every accumulated sample is the registered value, i.e. the ADC value from the previous cycle.
- States: IDLE, SETTLE, ACCUM, DONE.
- IDLE -> SETTLE: on an edge where start=1 and swiptAlive=1 (edge E0). If SETTLE_CYC=0, go directly to ACCUM.
- SETTLE: lasts exactly SETTLE_CYC cycles, then -> ACCUM.
- ACCUM entry: accumulator cleared; running max = 0; running min = all-ones; decimation counter = 0.
  - A sample is taken when the decimation counter = 0. The counter wraps at DECIM-1.
  - Each sample: acc += sample, update running min/max, increment sample count.
  - ACCUM lasts exactly N*DECIM cycles (N samples), then -> DONE.
- DONE (one cycle): valid=1.
  - mean = acc[ADC_W+LOG2_N-1:LOG2_N] (truncating); peak/trough = running max/min.
  - Next state: ACCUM (fresh window) if cont=1 and swiptAlive=1, else IDLE.
- Timing: with SETTLE_CYC=S, valid is high in the cycle following edge E0+S+N*DECIM. busy drops on the following edge unless continuing.
- Width: accumulator is ADC_W+LOG2_N bits. Full-scale input (0xFFF for N samples) must not overflow.
- start while busy: ignored; no queuing.
- start and swiptAlive low on the same edge: not accepted.
- swiptAlive low in SETTLE/ACCUM/DONE: synchronous abort to IDLE on that edge.
  - busy=0; no valid strobe.
  - mean/peak/trough keep the last completed values.
- valid is never high for more than one consecutive cycle except in continuous mode with DECIM*N=1, which is not supported; N*DECIM>=2 is required.
- Outputs change only in the DONE cycle or on reset.

Decomposition:
- Shared package swipt_pkg: ADC_W constant; state enum {IDLE, SETTLE, ACCUM, DONE}; default DECIM/LOG2_N/SETTLE_CYC values; ADC full-scale constant 12'hFFF.
- One sub-module, tick_gen: decimation counter with synchronous clear, producing the sample-enable pulse. The settle and sample counters stay in the top module.

Test Plan:
- Basic window: DECIM=4, LOG2_N=2, SETTLE_CYC=3, ADC constant 12'h400, start pulse at E0 -> valid exactly at cycle E0+20; mean=peak=trough=12'h400; busy high from E0+1 to E0+20.
- Ramp: DECIM=1, LOG2_N=2, SETTLE_CYC=0, registered samples 10,20,30,41 -> mean=25 (floor of 101/4); peak=41; trough=10.
- Overflow: ADC=12'hFFF, LOG2_N=6 -> mean=12'hFFF, no wrap; then ADC=0 -> mean=0, trough=0, peak=0.
- Abort: drop swiptAlive mid-ACCUM -> busy=0 next cycle; no valid; outputs retain the previous window (e.g. 12'h400). A subsequent start completes normally.
- Continuous mode: cont=1, S=3, DECIM=4, N=4 -> valid pulses at E0+20, E0+37, E0+54 (period N*DECIM+1); no settle between windows.
- Async reset: assert nrst low mid-SETTLE, between clock edges -> all outputs 0 immediately. start is ignored while nrst is low.
